// File: rtl/seg7_pkg.sv
// Shared constants and types for the 21-bit score segment bus.
// Used by the score encoder and the scan driver.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int BUS_W = 3 * SEG_W;
  localparam int H_LSB = 0;
  localparam int T_LSB = 7;
  localparam int O_LSB = 14;

  localparam logic [SEG_W-1:0] SEG_ZERO = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    DIG_H = 2'd0,
    DIG_T = 2'd1,
    DIG_O = 2'd2
  } dig_idx_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_st_t;

endpackage

// File: rtl/seg7_scan_tick_gen.sv
// Slot counter for the digit scan: counts 0..DIV-1 and flags the
// last clock of a slot and the blank window at its start.
module scan_tick_gen #(
  parameter int DIV          = 27000,
  parameter int BLANK_CYCLES = 270,
  parameter int CW           = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          blank
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BEND = CW'(BLANK_CYCLES);

  assign wrap  = (cnt == LAST);
  assign blank = (cnt < BEND);

  always_ff @(posedge clk) begin
    if (rst || !enable) cnt <= '0;
    else if (wrap)      cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes three 7-seg codes onto one segment bus with
// blank gaps, leading-zero suppression and per-frame snapshots.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 27000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 270,
  parameter bit SEG_ACT_LOW  = 1'b0,
  parameter bit DIG_ACT_LOW  = 1'b1,
  parameter bit SUPPRESS_LZ  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [BUS_W-1:0] display_puntaje,
  output logic [SEG_W-1:0] seg_out,
  output logic [2:0]       digit_sel,
  output logic             frame_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SEG_W-1:0] SEG_POL = {SEG_W{SEG_ACT_LOW}};
  localparam logic [2:0]       DIG_POL = {3{DIG_ACT_LOW}};

  logic [CW-1:0]    cnt;
  logic             wrap;
  logic             blank;

  dig_idx_t         idx_q, idx_d;
  logic [BUS_W-1:0] snap_q, snap_d;
  logic             fresh_q, fresh_d;
  logic [SEG_W-1:0] seg_d;
  logic [2:0]       dig_d;
  logic             tick_d;

  slot_st_t         st;
  logic [BUS_W-1:0] cur;
  logic [SEG_W-1:0] h, t, o, code;
  logic             hz, tz;
  logic [2:0]       sel;

  scan_tick_gen #(
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CW           (CW)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .cnt    (cnt),
    .wrap   (wrap),
    .blank  (blank)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= DIG_H;
      snap_q     <= '0;
      fresh_q    <= 1'b1;
      seg_out    <= SEG_OFF ^ SEG_POL;
      digit_sel  <= 3'b000 ^ DIG_POL;
      frame_tick <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      fresh_q    <= fresh_d;
      seg_out    <= seg_d ^ SEG_POL;
      digit_sel  <= dig_d ^ DIG_POL;
      frame_tick <= tick_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    snap_d  = snap_q;
    fresh_d = !enable;
    seg_d   = SEG_OFF;
    dig_d   = 3'b000;
    tick_d  = 1'b0;
    code    = SEG_OFF;
    sel     = 3'b000;
    st      = blank ? ST_BLANK : ST_SHOW;

    // a fresh start shows the live input straight away
    cur = fresh_q ? display_puntaje : snap_q;
    h   = cur[H_LSB +: SEG_W];
    t   = cur[T_LSB +: SEG_W];
    o   = cur[O_LSB +: SEG_W];
    hz  = SUPPRESS_LZ && (h == SEG_ZERO);
    tz  = hz && (t == SEG_ZERO);

    case (idx_q)
      DIG_H:   begin sel = 3'b001; code = hz ? SEG_OFF : h; end
      DIG_T:   begin sel = 3'b010; code = tz ? SEG_OFF : t; end
      DIG_O:   begin sel = 3'b100; code = o; end
      default: begin sel = 3'b000; code = SEG_OFF; end
    endcase

    if (enable) begin
      if (fresh_q || (wrap && idx_q == DIG_O)) snap_d = display_puntaje;
      tick_d = wrap && (idx_q == DIG_O);
      if (st == ST_SHOW) begin
        seg_d = code;
        dig_d = sel;
      end
      if (wrap) begin
        case (idx_q)
          DIG_H:   idx_d = DIG_T;
          DIG_T:   idx_d = DIG_O;
          default: idx_d = DIG_H;
        endcase
      end else if (idx_q != DIG_H && idx_q != DIG_T && idx_q != DIG_O) begin
        idx_d = DIG_H;
      end
    end else begin
      idx_d = DIG_H;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with a frame-position
// reference model; DIV=10, BLANK_CYCLES=2, active-high pins.
module tb_seg7_scan_driver;

  localparam int DIVM  = 10;
  localparam int BLANK = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] dig;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [20:0] bus;
  logic [6:0]  seg_out;
  logic [2:0]  digit_sel;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // model state: clocks since scan restart, frame snapshot
  int         pos = 0;
  bit         need_fresh = 1'b1;
  logic [6:0] snap [3];

  logic [6:0] dcode [10];

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ       (100),
    .SCAN_HZ      (10),
    .BLANK_CYCLES (BLANK),
    .SEG_ACT_LOW  (1'b0),
    .DIG_ACT_LOW  (1'b0),
    .SUPPRESS_LZ  (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .display_puntaje (bus),
    .seg_out         (seg_out),
    .digit_sel       (digit_sel),
    .frame_tick      (frame_tick)
  );

  function automatic logic [20:0] mk(input logic [6:0] hh, tt, oo);
    return {oo, tt, hh};
  endfunction

  function automatic exp_t model(input logic r, input logic e,
                                 input logic [20:0] b);
    exp_t x;
    int slot, off;
    x = '0;
    if (r || !e) begin
      pos = 0;
      need_fresh = 1'b1;
      return x;
    end
    if (need_fresh) begin
      snap[0] = b[6:0];
      snap[1] = b[13:7];
      snap[2] = b[20:14];
      need_fresh = 1'b0;
    end
    slot = (pos / DIVM) % 3;
    off  = pos % DIVM;
    if (off >= BLANK) begin
      x.dig = 3'b001 << slot;
      x.seg = snap[slot];
      if (slot == 0 && snap[0] == 7'b0111111) x.seg = '0;
      if (slot == 1 && snap[0] == 7'b0111111 &&
          snap[1] == 7'b0111111) x.seg = '0;
    end
    x.tick = (pos % (3 * DIVM)) == (3 * DIVM - 1);
    if (x.tick) begin
      snap[0] = b[6:0];
      snap[1] = b[13:7];
      snap[2] = b[20:14];
    end
    pos++;
    return x;
  endfunction

  task automatic step(input logic r, input logic e, input logic [20:0] b);
    exp_t x;
    rst = r;
    enable = e;
    bus = b;
    x = model(r, e, b);
    @(posedge clk);
    q.push_back(x);
    #2;
  endtask

  task automatic run(input int n, input logic [20:0] b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, b);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (seg_out !== x.seg || digit_sel !== x.dig ||
            frame_tick !== x.tick) begin
          errors++;
          $display("FAIL pins t=%0t seg=%b/%b dig=%b/%b tick=%b/%b (got/exp)",
                   $time, seg_out, x.seg, digit_sel, x.dig,
                   frame_tick, x.tick);
        end
      end
    end
  end

  initial begin : stim
    logic [20:0] b;
    int guard;
    dcode[0] = 7'b0111111; dcode[1] = 7'b0000110;
    dcode[2] = 7'b1011011; dcode[3] = 7'b1001111;
    dcode[4] = 7'b1100110; dcode[5] = 7'b1101101;
    dcode[6] = 7'b1111101; dcode[7] = 7'b0000111;
    dcode[8] = 7'b1111111; dcode[9] = 7'b1101111;
    rst = 1'b1; enable = 1'b1; bus = '0;
    #2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    run(60, mk(dcode[1], dcode[2], dcode[3]));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    run(30, mk(dcode[0], dcode[0], dcode[7]));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    run(30, mk(dcode[0], dcode[4], dcode[0]));
    run(30, mk(dcode[0], dcode[0], dcode[0]));
    // tearing: change input inside the tens slot
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    run(15, mk(dcode[1], dcode[2], dcode[3]));
    run(45, mk(dcode[9], dcode[9], dcode[9]));
    // enable dropped mid-tens slot, then resumed
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    run(14, mk(dcode[5], dcode[6], dcode[8]));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, mk(dcode[5], dcode[6], dcode[8]));
    run(35, mk(dcode[4], dcode[0], dcode[1]));
    // reset mid-SHOW
    step(1'b1, 1'b1, mk(dcode[4], dcode[0], dcode[1]));
    run(35, mk(dcode[2], dcode[3], dcode[4]));
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 3; k++) begin
        logic [6:0] c;
        if ($urandom_range(9) < 4) c = dcode[0];
        else if ($urandom_range(9) < 8) c = dcode[$urandom_range(9)];
        else c = 7'($urandom);
        b[k*7 +: 7] = c;
      end
      if ($urandom_range(99) < 10) bus = b;
      else b = bus;
      step($urandom_range(499) == 0, $urandom_range(199) != 0, b);
    end
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
